// File: rtl/debounce_pkg.sv
// Shared constants and types for the pushbutton debouncer family.
package debounce_pkg;

  localparam int CLK_HZ = 100000000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEF_STABLE_CYCLES = ms_to_cycles(5);
  localparam int DEF_HOLD_CYCLES   = ms_to_cycles(500);
  localparam int DEF_REPEAT_CYCLES = ms_to_cycles(100);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stable counter, edge strobes and hold-to-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = 1,
  parameter int REP_W         = 27,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic button_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   rise;
  logic                   fall;

  assign sync   = sync_sr[SYNC_STAGES-1];
  assign accept = (sync != button_state) && (cnt == STABLE_LAST);
  assign rise   = accept && sync;
  assign fall   = accept && !sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_sr       <= '0;
      cnt           <= '0;
      button_state  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], btn};
      // Compare-then-clear keeps the counter from ever wrapping.
      if (sync == button_state) begin
        cnt <= '0;
      end else if (cnt == STABLE_LAST) begin
        button_state <= sync;
        cnt          <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press_pulse   <= rise;
      release_pulse <= fall;
    end
  end

  if (REPEAT_EN != 0) begin : g_repeat
    localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] RPT_LAST  = REP_W'(REPEAT_CYCLES - 1);

    rpt_state_e       state, state_nx;
    logic [REP_W-1:0] rcnt, rcnt_nx;
    logic             rep_nx;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state        <= IDLE;
        rcnt         <= '0;
        repeat_pulse <= 1'b0;
      end else begin
        state        <= state_nx;
        rcnt         <= rcnt_nx;
        repeat_pulse <= rep_nx;
      end
    end

    // Release takes priority so a repeat never lands on the release strobe.
    always_comb begin
      state_nx = state;
      rcnt_nx  = rcnt;
      rep_nx   = 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = HOLD;
            rcnt_nx  = '0;
          end
        end
        HOLD: begin
          if (fall) begin
            state_nx = IDLE;
            rcnt_nx  = '0;
          end else if (rcnt == HOLD_LAST) begin
            rep_nx   = 1'b1;
            state_nx = RPT;
            rcnt_nx  = '0;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end
        RPT: begin
          if (fall) begin
            state_nx = IDLE;
            rcnt_nx  = '0;
          end else if (rcnt == RPT_LAST) begin
            rep_nx  = 1'b1;
            rcnt_nx = '0;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          rcnt_nx  = '0;
        end
      endcase
    end
  end else begin : g_no_repeat
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounced channels feeding the control FSM with clean single-cycle events.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int REP_W         = 27,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] button_state,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] repeat_pulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REP_W        (REP_W),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn_in[i]),
      .button_state (button_state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench: a sliding-window/elapsed-time reference predicts every cycle of all outputs.
module tb_multi_debouncer;

  localparam int NUM_CH        = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int CNT_W         = 20;
  localparam int STABLE_CYCLES = 4;
  localparam int REPEAT_EN     = 1;
  localparam int REP_W         = 27;
  localparam int HOLD_CYCLES   = 10;
  localparam int REPEAT_CYCLES = 5;
  localparam int HL            = SYNC_STAGES + STABLE_CYCLES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] btn_in;
  logic [NUM_CH-1:0] button_state, press_pulse, release_pulse, repeat_pulse;

  multi_debouncer #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W),
    .STABLE_CYCLES(STABLE_CYCLES), .REPEAT_EN(REPEAT_EN), .REP_W(REP_W),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .button_state(button_state), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    assert (STABLE_CYCLES >= 2 && STABLE_CYCLES <= (1 << CNT_W) &&
            HOLD_CYCLES <= (1 << REP_W) && REPEAT_CYCLES <= (1 << REP_W))
      else $fatal(1, "[TB] parameter does not fit its counter width");
  end

  typedef struct packed {
    logic [NUM_CH-1:0] st;
    logic [NUM_CH-1:0] prs;
    logic [NUM_CH-1:0] rel;
    logic [NUM_CH-1:0] rep;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   press_cnt[NUM_CH];
  int   rel_cnt[NUM_CH];
  int   rep_cnt[NUM_CH];

  // Reference state: raw samples (index 0 = newest), accepted level, press time.
  logic [NUM_CH-1:0] smp[HL];
  logic [NUM_CH-1:0] m_state;
  int                m_e;
  int                m_press_e[NUM_CH];
  bit                m_held[NUM_CH];

  task automatic predict_and_step();
    exp_t x;
    bit   flip;
    int   d;
    x = '0;
    if (!rst_n) begin
      for (int i = 0; i < HL; i++) smp[i] = '0;
      m_state = '0;
      m_e     = 0;
      for (int c = 0; c < NUM_CH; c++) m_held[c] = 1'b0;
    end else begin
      m_e++;
      for (int i = HL - 1; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = btn_in;
      for (int c = 0; c < NUM_CH; c++) begin
        // A new level is accepted once the last STABLE_CYCLES synchronised samples all differ.
        flip = 1'b1;
        for (int j = SYNC_STAGES; j < HL; j++)
          if (smp[j][c] == m_state[c]) flip = 1'b0;
        if (flip) begin
          m_state[c] = ~m_state[c];
          if (m_state[c]) begin
            x.prs[c] = 1'b1;
            m_press_e[c] = m_e;
            m_held[c] = 1'b1;
          end else begin
            x.rel[c] = 1'b1;
            m_held[c] = 1'b0;
          end
        end else if (m_held[c]) begin
          d = m_e - m_press_e[c];
          if (d >= HOLD_CYCLES && ((d - HOLD_CYCLES) % REPEAT_CYCLES) == 0) x.rep[c] = 1'b1;
        end
      end
    end
    x.st = m_state;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) predict_and_step();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: one comparison of all four outputs per clock edge.
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    cyc++;
    g = {button_state, press_pulse, release_pulse, repeat_pulse};
    for (int c = 0; c < NUM_CH; c++) begin
      press_cnt[c] += int'(press_pulse[c]);
      rel_cnt[c]   += int'(release_pulse[c]);
      rep_cnt[c]   += int'(repeat_pulse[c]);
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty cycle %0d: outputs %h with no prediction", cyc, g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: st/prs/rel/rep got %h_%h_%h_%h expected %h_%h_%h_%h",
                 cyc, g.st, g.prs, g.rel, g.rep, e.st, e.prs, e.rel, e.rep);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p0, p1, r3, rl3, g2;
    int run_len[NUM_CH];
    for (int c = 0; c < NUM_CH; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; rep_cnt[c] = 0; m_press_e[c] = 0;
    end

    // Reset with all buttons held, then fresh presses after release.
    rst_n = 1'b0; btn_in = '1;
    run(5);
    rst_n = 1'b1;
    p0 = press_cnt[0];
    run(8);
    check_int("reset_hold_press_ch0", press_cnt[0] - p0, 1);
    btn_in = '0;
    run(10);

    // Clean press on channel 0.
    p0 = press_cnt[0];
    btn_in[0] = 1'b1;
    run(10);
    check_int("clean_press_ch0", press_cnt[0] - p0, 1);

    // Bouncing channel 1: toggles every 2 cycles, then settles high.
    p1 = press_cnt[1];
    for (int i = 0; i < 10; i++) begin
      btn_in[1] = ~btn_in[1];
      run(2);
    end
    btn_in[1] = 1'b1;
    run(10);
    check_int("bounce_single_press_ch1", press_cnt[1] - p1, 1);

    // Short glitch on channel 2.
    g2 = press_cnt[2] + rel_cnt[2] + rep_cnt[2];
    btn_in[2] = 1'b1;
    run(3);
    btn_in[2] = 1'b0;
    run(10);
    check_int("glitch_no_activity_ch2", press_cnt[2] + rel_cnt[2] + rep_cnt[2] - g2, 0);

    // Long hold on channel 3: six repeats, then a release with no further repeats.
    r3 = rep_cnt[3]; rl3 = rel_cnt[3];
    btn_in[3] = 1'b1;
    run(40);
    btn_in[3] = 1'b0;
    run(15);
    check_int("hold_repeats_ch3", rep_cnt[3] - r3, 6);
    check_int("hold_release_ch3", rel_cnt[3] - rl3, 1);

    // Simultaneous press on 0/1, reset while repeating, fresh press afterwards.
    btn_in = '0;
    run(10);
    p0 = press_cnt[0]; p1 = press_cnt[1];
    btn_in[1:0] = 2'b11;
    run(25);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(10);
    check_int("sim_press_reset_ch0", press_cnt[0] - p0, 2);
    check_int("sim_press_reset_ch1", press_cnt[1] - p1, 2);
    btn_in = '0;
    run(10);

    // Randomised run lengths mix glitches, accepted edges, long holds and stray resets.
    for (int c = 0; c < NUM_CH; c++) run_len[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (run_len[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          run_len[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40)
                                                  : $urandom_range(1, 7);
        end
        run_len[c]--;
      end
      rst_n = ($urandom_range(0, 499) != 0);
      predict_and_step();
    end
    rst_n = 1'b1;
    run(5);
    #2;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
